// File: rtl/hex_display_scan.sv
// hex_display_scan: multiplexed seven-segment scanner with prescaler and frame-coherent capture
module hex_display_scan #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   input  logic                    enable,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic [3:0]              hex_num,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_done
);
   localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
   localparam int SW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   logic [PW-1:0]           pre;
   logic [SW-1:0]           slot;
   logic [4*NUM_DIGITS-1:0] snap_val;
   logic [NUM_DIGITS-1:0]   snap_dp;
   logic                    snap_blz;
   logic                    pre_tc, slot_tc, blanked, dark;
   logic [3:0]              nib;
   logic [6:0]              dec;
   assign pre_tc  = pre == PW'(REFRESH_DIV - 1);
   assign slot_tc = slot == SW'(NUM_DIGITS - 1);
   assign nib     = snap_val[{slot, 2'b00} +: 4];
   assign dark    = !enable || blanked;
   // a digit is a leading zero when it and every digit above it are zero
   always_comb begin
      blanked = snap_blz && slot != '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (SW'(i) >= slot && snap_val[4*i +: 4] != 4'h0) blanked = 1'b0;
   end
   always_comb begin
      case (nib)
         4'h0: dec = 7'h40;
         4'h1: dec = 7'h79;
         4'h2: dec = 7'h24;
         4'h3: dec = 7'h30;
         4'h4: dec = 7'h19;
         4'h5: dec = 7'h12;
         4'h6: dec = 7'h02;
         4'h7: dec = 7'h78;
         4'h8: dec = 7'h00;
         4'h9: dec = 7'h10;
         4'hA: dec = 7'h08;
         4'hB: dec = 7'h03;
         4'hC: dec = 7'h46;
         4'hD: dec = 7'h21;
         4'hE: dec = 7'h06;
         default: dec = 7'h0E;
      endcase
   end
   always_ff @(posedge clk)
      if (reset) begin
         pre        <= '0;
         slot       <= '0;
         snap_val   <= '0;
         snap_dp    <= '0;
         snap_blz   <= 1'b0;
         digit_sel  <= '1;
         hex_num    <= 4'hF;
         seg        <= 7'h7F;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         pre <= pre_tc ? '0 : pre + 1'b1;
         if (pre_tc) slot <= slot_tc ? '0 : slot + 1'b1;
         if (pre == '0 && slot == '0) begin
            snap_val <= value;
            snap_dp  <= dp_in;
            snap_blz <= blank_lz;
         end
         digit_sel  <= dark ? '1 : ~(NUM_DIGITS'(1) << slot);
         hex_num    <= nib;
         seg        <= dark ? 7'h7F : dec;
         dp         <= dark | ~snap_dp[slot];
         frame_done <= pre_tc && slot_tc;
      end
endmodule

// File: tb/tb_hex_display_scan.sv
// tb_hex_display_scan: random and directed checks of three scanner sizes against a timeline model
module tb_hex_display_scan;
   localparam int NS [3] = '{4, 1, 8};
   localparam int RS [3] = '{4, 2, 2};
   localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic clk = 1'b0, rst = 1'b1, blz = 1'b0, en = 1'b1;
   logic [31:0] val = 32'h0;
   logic [7:0] dpi = 8'h0;
   logic [3:0] ds0;
   logic [0:0] ds1;
   logic [7:0] ds2;
   logic [2:0][7:0] dsel;
   logic [2:0][3:0] hx;
   logic [2:0][6:0] sg;
   logic [2:0] dpo, fd;
   int passed = 0, total = 0, e = 0;
   bit armed = 0;
   int t [3];
   logic [31:0] sv [3];
   logic [7:0] sd [3], e_sel [3];
   logic sb [3], e_dp [3], e_fd [3];
   logic [3:0] e_hx [3];
   logic [6:0] e_sg [3];
   always #5 clk = ~clk;
   assign dsel[0] = {4'hF, ds0};
   assign dsel[1] = {7'h7F, ds1};
   assign dsel[2] = ds2;
   hex_display_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4)) u0 (.clk(clk), .reset(rst), .value(val[15:0]),
      .dp_in(dpi[3:0]), .blank_lz(blz), .enable(en), .digit_sel(ds0), .hex_num(hx[0]), .seg(sg[0]),
      .dp(dpo[0]), .frame_done(fd[0]));
   hex_display_scan #(.NUM_DIGITS(1), .REFRESH_DIV(2)) u1 (.clk(clk), .reset(rst), .value(val[3:0]),
      .dp_in(dpi[0:0]), .blank_lz(blz), .enable(en), .digit_sel(ds1), .hex_num(hx[1]), .seg(sg[1]),
      .dp(dpo[1]), .frame_done(fd[1]));
   hex_display_scan #(.NUM_DIGITS(8), .REFRESH_DIV(2)) u2 (.clk(clk), .reset(rst), .value(val),
      .dp_in(dpi), .blank_lz(blz), .enable(en), .digit_sel(ds2), .hex_num(hx[2]), .seg(sg[2]),
      .dp(dpo[2]), .frame_done(fd[2]));
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s got %h want %h at %0t", nm, got, exp, $time);
      else passed++;
   endtask
   // t counts edges since reset release: slot = (t/R)%N, capture when t%(N*R)==0
   task automatic model_edge(input int i);
      int n, r, k;
      logic blk, dark;
      logic [3:0] nb;
      n = NS[i];
      r = RS[i];
      k = (t[i] / r) % n;
      nb = 4'(sv[i] >> (4 * k));
      blk = sb[i] && k > 0 && (sv[i] >> (4 * k)) == 0;
      dark = !en || blk;
      e_sel[i] = dark ? 8'hFF : ~(8'd1 << k);
      e_hx[i] = nb;
      e_sg[i] = dark ? 7'h7F : DEC[nb];
      e_dp[i] = dark || !sd[i][k];
      e_fd[i] = ((t[i] + 1) % (n * r)) == 0;
      if (t[i] % (n * r) == 0) begin
         sv[i] = val & 32'((64'd1 << (4 * n)) - 1);
         sd[i] = dpi & 8'((16'd1 << n) - 1);
         sb[i] = blz;
      end
      t[i]++;
   endtask
   initial forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++)
         if (rst) begin
            armed = 1;
            t[i] = 0;
            sv[i] = 0;
            sd[i] = 0;
            sb[i] = 0;
            e_sel[i] = 8'hFF;
            e_hx[i] = 4'hF;
            e_sg[i] = 7'h7F;
            e_dp[i] = 1;
            e_fd[i] = 0;
         end else model_edge(i);
   end
   initial forever begin
      @(negedge clk);
      if (armed)
         for (int i = 0; i < 3; i++)
            chk($sformatf("model_u%0d", i), {dsel[i], hx[i], sg[i], dpo[i], fd[i]},
                {e_sel[i], e_hx[i], e_sg[i], e_dp[i], e_fd[i]});
   end
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic goto(input int edge_n);
      tick(edge_n - e);
      e = edge_n;
   endtask
   task automatic restart();
      rst = 1;
      tick(2);
      chk("reset_vals", {ds0, hx[0], sg[0], dpo[0], fd[0]}, {4'hF, 4'hF, 7'h7F, 1'b1, 1'b0});
      rst = 0;
      e = 0;
   endtask
   task automatic lit(input string nm, input logic [3:0] s, input logic [3:0] h, input logic [6:0] g, input logic d);
      chk(nm, {ds0, hx[0], sg[0], dpo[0]}, {s, h, g, d});
   endtask
   initial begin
      val = 32'h12AF;
      restart();
      goto(2);  lit("first_d0", 4'b1110, 4'hF, 7'h0E, 1'b1);
      goto(6);  lit("first_d1", 4'b1101, 4'hA, 7'h08, 1'b1);
      goto(10); lit("first_d2", 4'b1011, 4'h2, 7'h24, 1'b1);
      val = 32'h0;
      goto(14); lit("coherent_d3", 4'b0111, 4'h1, 7'h79, 1'b1);
      goto(16); chk("frame_done_hi", fd[0], 1);
      goto(17); chk("frame_done_lo", fd[0], 0);
      goto(18); lit("next_d0", 4'b1110, 4'h0, 7'h40, 1'b1);
      goto(22); lit("next_d1", 4'b1101, 4'h0, 7'h40, 1'b1);
      val = 32'h0050;
      blz = 1;
      dpi = 8'b1000;
      restart();
      goto(2);  lit("lz_d0", 4'b1110, 4'h0, 7'h40, 1'b1);
      goto(6);  lit("lz_d1", 4'b1101, 4'h5, 7'h12, 1'b1);
      goto(10); lit("lz_d2", 4'b1111, 4'h0, 7'h7F, 1'b1);
      goto(14); lit("lz_d3_dp", 4'b1111, 4'h0, 7'h7F, 1'b1);
      val = 32'h0;
      goto(18); lit("lz0_d0", 4'b1110, 4'h0, 7'h40, 1'b1);
      goto(22); lit("lz0_d1", 4'b1111, 4'h0, 7'h7F, 1'b1);
      val = 32'h8888;
      blz = 0;
      dpi = 8'b0010;
      restart();
      goto(2);  lit("dp_d0", 4'b1110, 4'h8, 7'h00, 1'b1);
      goto(6);  lit("dp_d1", 4'b1101, 4'h8, 7'h00, 1'b0);
      goto(10); lit("dp_d2", 4'b1011, 4'h8, 7'h00, 1'b1);
      en = 0;
      goto(11); lit("dark_a", 4'b1111, 4'h8, 7'h7F, 1'b1);
      goto(15); lit("dark_b", 4'b1111, 4'h8, 7'h7F, 1'b1);
      en = 1;
      goto(16); lit("resume_d3", 4'b0111, 4'h8, 7'h00, 1'b1);
      goto(26);
      restart();
      goto(2);  lit("rst_mid_d0", 4'b1110, 4'h8, 7'h00, 1'b1);
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(7) == 0) begin
            case ($urandom_range(3))
               0: val = $urandom;
               1: val = 32'h0;
               default: val = $urandom >> (4 * $urandom_range(7));
            endcase
            dpi = 8'($urandom);
            blz = 1'($urandom);
         end
         if ($urandom_range(15) == 0) en = ~en;
         rst = $urandom_range(299) == 0;
         tick(1);
      end
      rst = 0;
      en = 1;
      tick(40);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
